codec_cfg_sequencer: RTL and testbench
======================================

Name: codec_cfg_sequencer

Overview:
- Sequences audio-codec configuration over the existing shared I2C byte engine (24-bit word in, GO/END handshake).
- After reset, writes the 11-entry codec initialisation table in order.
- Then serves headphone-volume up/down requests by rewriting only the headphone-out register.
- Runs on the 1 MHz I2C control clock. Replaces ad-hoc switch-driven data muxing with an ordered, timeout-protected transaction scheduler.

Parameters:
DEV_ADDR, 8'h34, codec write address byte, I2C_DATA[23:16]
VOL_DEFAULT, 7'h79, volume after reset
VOL_MIN, 7'h30, lower volume clamp
VOL_MAX, 7'h7F, upper volume clamp
VOL_STEP, 4, volume increment per request
GAP_CYC, 16, idle CLOCK cycles between transactions
TIMEOUT_CYC, 4095, max cycles per transaction before retry
MAX_RETRY, 3, retries before ERR

Ports:
CLOCK  in  1  control clock
RESET  in  1  asynchronous, active-low reset
START  in  1  single-cycle pulse: rerun full initialisation
VOL_UP  in  1  single-cycle pulse: raise volume
VOL_DN  in  1  single-cycle pulse: lower volume
END  in  1  from I2C engine: low while transferring, high when idle/done
GO  out  1  transaction request to I2C engine
I2C_DATA  out  24  {DEV_ADDR, reg[6:0], data[8:0]}
BUSY  out  1  high from LOAD through GAP
INIT_DONE  out  1  full table written successfully
ERR  out  1  retries exhausted
VOLUME  out  7  current headphone volume
CFG_INDEX  out  4  table index being or last written

Behaviour:
- Reset values: GO=0, I2C_DATA=0, BUSY=0, INIT_DONE=0, ERR=0, VOLUME=VOL_DEFAULT, CFG_INDEX=0. State after reset = IDLE with init pending, so the init sequence starts automatically.
- Table, low 16 bits by index:
  - 0: 0x1E00
  - 1: 0x0017
  - 2: 0x0217
  - 3: {7'h02,1'b1,1'b0,VOLUME}
  - 4: {7'h03,1'b1,1'b0,VOLUME}
  - 5: 0x0812
  - 6: 0x0A00
  - 7: 0x0C00
  - 8: 0x0E42
  - 9: 0x1000
  - 10: 0x1201
- VOLUME-dependent entries are sampled at LOAD.
- FSM states: IDLE, LOAD, ISSUE, WAIT_DONE, GAP, FAIL.
- IDLE:
  - If init pending: CFG_INDEX←0, go to LOAD.
  - Else if volume write pending and INIT_DONE: go to LOAD with word {7'h02,1'b1,1'b0,VOLUME}.
  - Else stay.
- LOAD: latch I2C_DATA, clear timeout counter, go to ISSUE.
- ISSUE: GO=1; when END=0, go to WAIT_DONE.
- WAIT_DONE: GO=1; when END=1, GO←0, go to GAP.
- GAP: count GAP_CYC cycles, then:
  - Init in progress, CFG_INDEX<10: CFG_INDEX+1, LOAD.
  - Init in progress, CFG_INDEX=10: INIT_DONE←1, clear init pending, go to IDLE.
  - Volume write: clear volume pending, go to IDLE.
- Timeout: counter runs in ISSUE and WAIT_DONE. When it reaches TIMEOUT_CYC: GO←0, wait GAP, reissue the same word. Retry count resets per word. After MAX_RETRY failed retries: ERR←1, state FAIL, GO=0.
- FAIL: holds until START or reset. START clears ERR and retry count and restarts init.
- Latency: first RESET release cycle → LOAD; second → GO=1. GO never drops while END is low except on timeout.
- START:
  - Sets init pending and clears INIT_DONE.
  - If mid-transaction, the current transaction completes normally, then the sequence restarts at index 0; the transaction is never aborted.
- Volume requests, accepted in any state including FAIL and during init:
  - VOL_UP: VOLUME←min(VOLUME+VOL_STEP, VOL_MAX), computed in 8 bits, no wrap.
  - VOL_DN: VOLUME←max(VOLUME−VOL_STEP, VOL_MIN), no underflow.
  - Effect is the next cycle. Sets volume write pending.
  - Simultaneous VOL_UP and VOL_DN: ignored, no change, no pending.
  - Multiple requests while busy coalesce into a single pending write of the latest VOLUME.
- Init has priority over a pending volume write. The volume write is issued only after INIT_DONE=1.
- A request at the clamp still issues a write (idempotent).
- BUSY=1 in LOAD, ISSUE, WAIT_DONE, GAP; 0 in IDLE and FAIL.

Test Plan:
- Reset release, END model (low 30 cycles after GO, then high) → 11 transactions in order: I2C_DATA=0x341E00 … 0x341201. Entries 3/4 = 0x340579/0x340779. INIT_DONE=1 after the last GAP. GO=1 on the 2nd cycle after reset.
- After init, 2× VOL_UP from 0x79 → VOLUME 0x7D then 0x7F (clamped). One coalesced write of 0x34057F.
- Volume 0x32 with VOL_DN → 0x30. Second VOL_DN → stays 0x30, write 0x340530 issued. VOL_UP+VOL_DN in the same cycle → no change, no write.
- END held high (never accepts) → GO drops after 4095 cycles, same word reissued 3 times, then ERR=1, GO=0, BUSY=0. START → ERR=0, init restarts at 0x341E00.
- START pulse while CFG_INDEX=5 is in WAIT_DONE → index-5 transaction completes, next I2C_DATA=0x341E00, INIT_DONE=0 until index 10 finishes.
- RESET asserted mid-WAIT_DONE → GO, I2C_DATA, and all flags drop immediately; VOLUME=0x79; init reruns after release.

Source files
------------

// File: rtl/codec_cfg_sequencer.sv
// Audio-codec configuration sequencer: writes the codec init table, then
// headphone-volume updates, over the shared I2C engine with timeout and retry.
module codec_cfg_sequencer #(
  parameter logic [7:0] DEV_ADDR    = 8'h34,
  parameter logic [6:0] VOL_DEFAULT = 7'h79,
  parameter logic [6:0] VOL_MIN     = 7'h30,
  parameter logic [6:0] VOL_MAX     = 7'h7F,
  parameter int         VOL_STEP    = 4,
  parameter int         GAP_CYC     = 16,
  parameter int         TIMEOUT_CYC = 4095,
  parameter int         MAX_RETRY   = 3
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        START,
  input  logic        VOL_UP,
  input  logic        VOL_DN,
  input  logic        END,
  output logic        GO,
  output logic [23:0] I2C_DATA,
  output logic        BUSY,
  output logic        INIT_DONE,
  output logic        ERR,
  output logic [6:0]  VOLUME,
  output logic [3:0]  CFG_INDEX
);

  localparam int GAP_W   = $clog2(GAP_CYC + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYC - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);
  localparam logic [3:0]         LAST_INDEX = 4'd10;
  localparam logic [7:0]         STEP8      = 8'(VOL_STEP);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD      = 3'd1;
  localparam logic [2:0] ISSUE     = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] GAP       = 3'd4;
  localparam logic [2:0] FAIL      = 3'd5;

  logic [2:0]         state;
  logic               init_pending;
  logic               restart;
  logic               vol_pending;
  logic               cur_is_init;
  logic               timed_out;
  logic [TO_W-1:0]    timeout_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [RETRY_W-1:0] retry_cnt;

  logic               vol_up_req;
  logic               vol_dn_req;
  logic [7:0]         vol_sum;
  logic [7:0]         vol_floor;
  logic [6:0]         vol_up_val;
  logic [6:0]         vol_dn_val;
  logic [15:0]        table_low;
  logic [23:0]        load_word;

  // Clamped volume arithmetic is done one bit wider so it can never wrap.
  always_comb begin
    vol_up_req = VOL_UP & ~VOL_DN;
    vol_dn_req = VOL_DN & ~VOL_UP;
    vol_sum    = {1'b0, VOLUME} + STEP8;
    vol_floor  = {1'b0, VOL_MIN} + STEP8;
    vol_up_val = (vol_sum > {1'b0, VOL_MAX}) ? VOL_MAX : vol_sum[6:0];
    vol_dn_val = ({1'b0, VOLUME} < vol_floor) ? VOL_MIN : VOLUME - STEP8[6:0];
  end

  always_comb begin
    table_low = 16'h0000;
    case (CFG_INDEX)
      4'd0:    table_low = 16'h1E00;
      4'd1:    table_low = 16'h0017;
      4'd2:    table_low = 16'h0217;
      4'd3:    table_low = {7'h02, 1'b1, 1'b0, VOLUME};
      4'd4:    table_low = {7'h03, 1'b1, 1'b0, VOLUME};
      4'd5:    table_low = 16'h0812;
      4'd6:    table_low = 16'h0A00;
      4'd7:    table_low = 16'h0C00;
      4'd8:    table_low = 16'h0E42;
      4'd9:    table_low = 16'h1000;
      4'd10:   table_low = 16'h1201;
      default: table_low = 16'h0000;
    endcase
    load_word = cur_is_init ? {DEV_ADDR, table_low}
                            : {DEV_ADDR, 7'h02, 1'b1, 1'b0, VOLUME};
  end

  always_comb begin
    BUSY = (state == LOAD) || (state == ISSUE) || (state == WAIT_DONE) || (state == GAP);
  end

  // The pending flag drops when a volume word is latched, so a request that
  // lands during that write re-arms it and the newest volume is never lost.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      VOLUME      <= VOL_DEFAULT;
      vol_pending <= 1'b0;
    end else begin
      if (state == LOAD && !cur_is_init) begin
        vol_pending <= 1'b0;
      end
      if (vol_up_req) begin
        VOLUME      <= vol_up_val;
        vol_pending <= 1'b1;
      end else if (vol_dn_req) begin
        VOLUME      <= vol_dn_val;
        vol_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state        <= IDLE;
      GO           <= 1'b0;
      I2C_DATA     <= 24'h000000;
      INIT_DONE    <= 1'b0;
      ERR          <= 1'b0;
      CFG_INDEX    <= 4'd0;
      init_pending <= 1'b1;
      restart      <= 1'b0;
      cur_is_init  <= 1'b0;
      timed_out    <= 1'b0;
      timeout_cnt  <= '0;
      gap_cnt      <= '0;
      retry_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (init_pending) begin
            CFG_INDEX   <= 4'd0;
            cur_is_init <= 1'b1;
            restart     <= 1'b0;
            state       <= LOAD;
          end else if (vol_pending && INIT_DONE) begin
            cur_is_init <= 1'b0;
            state       <= LOAD;
          end
        end
        LOAD: begin
          I2C_DATA    <= load_word;
          timeout_cnt <= '0;
          retry_cnt   <= '0;
          timed_out   <= 1'b0;
          GO          <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE, WAIT_DONE: begin
          if (state == ISSUE && !END) begin
            timeout_cnt <= timeout_cnt + TO_W'(1);
            state       <= WAIT_DONE;
          end else if (state == WAIT_DONE && END) begin
            GO      <= 1'b0;
            gap_cnt <= '0;
            state   <= GAP;
          end else if (timeout_cnt == TO_LAST) begin
            GO <= 1'b0;
            if (retry_cnt == RETRY_LAST) begin
              ERR   <= 1'b1;
              state <= FAIL;
            end else begin
              retry_cnt <= retry_cnt + RETRY_W'(1);
              timed_out <= 1'b1;
              gap_cnt   <= '0;
              state     <= GAP;
            end
          end else begin
            timeout_cnt <= timeout_cnt + TO_W'(1);
          end
        end
        GAP: begin
          if (gap_cnt != GAP_LAST) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end else if (timed_out) begin
            // A retry re-drives the already latched word unchanged.
            timed_out   <= 1'b0;
            timeout_cnt <= '0;
            GO          <= 1'b1;
            state       <= ISSUE;
          end else if (restart) begin
            state <= IDLE;
          end else if (cur_is_init) begin
            if (CFG_INDEX != LAST_INDEX) begin
              CFG_INDEX <= CFG_INDEX + 4'd1;
              state     <= LOAD;
            end else begin
              INIT_DONE    <= 1'b1;
              init_pending <= 1'b0;
              state        <= IDLE;
            end
          end else begin
            state <= IDLE;
          end
        end
        FAIL: begin
          GO <= 1'b0;
          if (START) begin
            ERR       <= 1'b0;
            retry_cnt <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          GO    <= 1'b0;
          state <= IDLE;
        end
      endcase

      // START wins over a same-cycle completion; the running word still finishes.
      if (START) begin
        init_pending <= 1'b1;
        restart      <= 1'b1;
        INIT_DONE    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Directed bench for codec_cfg_sequencer with a behavioural I2C engine that
// holds END low for 30 cycles per accepted transaction.
module tb_codec_cfg_sequencer;

  logic        CLOCK;
  logic        RESET;
  logic        START;
  logic        VOL_UP;
  logic        VOL_DN;
  logic        END;
  logic        GO;
  logic [23:0] I2C_DATA;
  logic        BUSY;
  logic        INIT_DONE;
  logic        ERR;
  logic [6:0]  VOLUME;
  logic [3:0]  CFG_INDEX;

  int          checkCount   = 0;
  int          passCount    = 0;
  logic        engineEnable = 1'b1;
  logic [23:0] txnQ[$];
  int          runLen       = 0;
  int          lastRunLen   = 0;
  int          earlyDrops   = 0;
  logic        prevGo       = 1'b0;

  localparam logic [23:0] INIT_TABLE [11] = '{
    24'h341E00, 24'h340017, 24'h340217, 24'h340579, 24'h340779, 24'h340812,
    24'h340A00, 24'h340C00, 24'h340E42, 24'h341000, 24'h341201
  };

  codec_cfg_sequencer dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .START     (START),
    .VOL_UP    (VOL_UP),
    .VOL_DN    (VOL_DN),
    .END       (END),
    .GO        (GO),
    .I2C_DATA  (I2C_DATA),
    .BUSY      (BUSY),
    .INIT_DONE (INIT_DONE),
    .ERR       (ERR),
    .VOLUME    (VOLUME),
    .CFG_INDEX (CFG_INDEX)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  // Engine model: accept GO, stay busy 30 cycles, then report done.
  initial begin
    END = 1'b1;
    forever begin
      @(negedge CLOCK);
      if (GO && engineEnable) begin
        END = 1'b0;
        repeat (30) @(negedge CLOCK);
        END = 1'b1;
        while (GO) @(negedge CLOCK);
      end
    end
  end

  // Log every issued word and measure how long GO stays high.
  initial begin
    forever begin
      @(negedge CLOCK);
      if (GO && !prevGo) txnQ.push_back(I2C_DATA);
      if (GO) begin
        runLen++;
      end else if (prevGo) begin
        lastRunLen = runLen;
        runLen     = 0;
        if (!END && RESET) earlyDrops++;
      end
      prevGo = GO;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic startIn, input logic upIn, input logic dnIn);
    START  = startIn;
    VOL_UP = upIn;
    VOL_DN = dnIn;
    @(negedge CLOCK);
    START  = 1'b0;
    VOL_UP = 1'b0;
    VOL_DN = 1'b0;
  endtask

  task automatic waitInitDone(input int budget);
    for (int i = 0; i < budget && !INIT_DONE; i++) @(negedge CLOCK);
    checkOutput("init_done_seen", 32'(INIT_DONE), 32'd1);
  endtask

  task automatic checkResetState(input string phase);
    checkOutput({phase, "_go"},        32'(GO),        32'd0);
    checkOutput({phase, "_data"},      32'(I2C_DATA),  32'd0);
    checkOutput({phase, "_busy"},      32'(BUSY),      32'd0);
    checkOutput({phase, "_init_done"}, 32'(INIT_DONE), 32'd0);
    checkOutput({phase, "_err"},       32'(ERR),       32'd0);
    checkOutput({phase, "_volume"},    32'(VOLUME),    32'h79);
    checkOutput({phase, "_cfg_index"}, 32'(CFG_INDEX), 32'd0);
  endtask

  function automatic logic [23:0] txnAt(input int idx);
    if (idx < txnQ.size()) return txnQ[idx];
    return 24'hFFFFFF;
  endfunction

  initial begin
    RESET  = 1'b0;
    START  = 1'b0;
    VOL_UP = 1'b0;
    VOL_DN = 1'b0;
    repeat (3) @(negedge CLOCK);
    checkResetState("reset");

    // Release: LOAD on the first edge, GO on the second.
    RESET = 1'b1;
    @(posedge CLOCK); #1;
    checkOutput("first_edge_busy", 32'(BUSY), 32'd1);
    checkOutput("first_edge_go",   32'(GO),   32'd0);
    @(posedge CLOCK); #1;
    checkOutput("second_edge_go",   32'(GO),       32'd1);
    checkOutput("second_edge_data", 32'(I2C_DATA), 32'h341E00);

    waitInitDone(2000);
    checkOutput("init_count", 32'(txnQ.size()), 32'd11);
    for (int i = 0; i < 11; i++)
      checkOutput($sformatf("init_word%0d", i), 32'(txnAt(i)), 32'(INIT_TABLE[i]));
    checkOutput("init_cfg_index", 32'(CFG_INDEX), 32'd10);
    checkOutput("init_busy",      32'(BUSY),      32'd0);

    // Two back-to-back raises coalesce into one clamped write.
    txnQ.delete();
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("vol_up1", 32'(VOLUME), 32'h7D);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("vol_up2_clamp", 32'(VOLUME), 32'h7F);
    repeat (100) @(negedge CLOCK);
    checkOutput("vol_up_count", 32'(txnQ.size()), 32'd1);
    checkOutput("vol_up_word",  32'(txnAt(0)),    32'h34057F);
    checkOutput("vol_up_busy",  32'(BUSY),        32'd0);

    // Step down to 0x33, then one more step clamps at the floor.
    txnQ.delete();
    for (int i = 0; i < 19; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("vol_dn_0x33", 32'(VOLUME), 32'h33);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("vol_dn_floor", 32'(VOLUME), 32'h30);
    repeat (150) @(negedge CLOCK);
    checkOutput("vol_dn_last_word", 32'(txnAt(txnQ.size() - 1)), 32'h340530);
    checkOutput("vol_dn_busy",      32'(BUSY),                    32'd0);

    txnQ.delete();
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("vol_dn_hold", 32'(VOLUME), 32'h30);
    repeat (100) @(negedge CLOCK);
    checkOutput("vol_clamp_count", 32'(txnQ.size()), 32'd1);
    checkOutput("vol_clamp_word",  32'(txnAt(0)),    32'h340530);

    txnQ.delete();
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("vol_both_volume", 32'(VOLUME), 32'h30);
    repeat (100) @(negedge CLOCK);
    checkOutput("vol_both_count", 32'(txnQ.size()), 32'd0);

    // Engine never answers: four attempts of 4095 cycles, then ERR.
    engineEnable = 1'b0;
    txnQ.delete();
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("to_volume", 32'(VOLUME), 32'h34);
    for (int i = 0; i < 20000 && !ERR; i++) @(negedge CLOCK);
    checkOutput("to_err",       32'(ERR),         32'd1);
    checkOutput("to_go",        32'(GO),          32'd0);
    checkOutput("to_busy",      32'(BUSY),        32'd0);
    checkOutput("to_attempts",  32'(txnQ.size()), 32'd4);
    checkOutput("to_word_first",32'(txnAt(0)),    32'h340534);
    checkOutput("to_word_last", 32'(txnAt(3)),    32'h340534);
    checkOutput("to_go_length", 32'(lastRunLen),  32'd4095);
    repeat (50) @(negedge CLOCK);
    checkOutput("fail_hold_err", 32'(ERR), 32'd1);

    engineEnable = 1'b1;
    txnQ.delete();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("start_clears_err", 32'(ERR),       32'd0);
    checkOutput("start_init_done",  32'(INIT_DONE), 32'd0);
    waitInitDone(2000);
    checkOutput("reinit_count", 32'(txnQ.size()), 32'd11);
    checkOutput("reinit_word0", 32'(txnAt(0)),    32'h341E00);
    checkOutput("reinit_word3", 32'(txnAt(3)),    32'h340534);

    // START while index 5 is on the bus: it completes, then init restarts.
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 1000 && !(CFG_INDEX == 4'd5 && GO && !END); i++) @(negedge CLOCK);
    checkOutput("idx5_in_flight", 32'(CFG_INDEX == 4'd5 && GO && !END), 32'd1);
    checkOutput("idx5_word",      32'(I2C_DATA), 32'h340812);
    txnQ.delete();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("idx5_init_done", 32'(INIT_DONE), 32'd0);
    checkOutput("idx5_not_aborted", 32'(GO), 32'd1);
    waitInitDone(2000);
    checkOutput("restart_count", 32'(txnQ.size()), 32'd11);
    checkOutput("restart_word0", 32'(txnAt(0)),    32'h341E00);
    checkOutput("early_go_drops", 32'(earlyDrops), 32'd0);

    // Asynchronous reset in the middle of a volume write.
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("pre_reset_volume", 32'(VOLUME), 32'h38);
    for (int i = 0; i < 200 && !(GO && !END); i++) @(negedge CLOCK);
    checkOutput("pre_reset_in_flight", 32'(GO && !END), 32'd1);
    #2 RESET = 1'b0;
    #1 checkResetState("async_reset");
    repeat (40) @(negedge CLOCK);
    txnQ.delete();
    RESET = 1'b1;
    waitInitDone(2000);
    checkOutput("post_reset_count", 32'(txnQ.size()), 32'd11);
    checkOutput("post_reset_word0", 32'(txnAt(0)),    32'h341E00);
    checkOutput("post_reset_word3", 32'(txnAt(3)),    32'h340579);
    checkOutput("post_reset_word10",32'(txnAt(10)),   32'h341201);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
